kyo_sprite_fetch: RTL and testbench
===================================

// Module: kyo_sprite_fetch
// PURPOSE
//  Drives the sprite ROM/palette pixel path: converts VGA draw coordinates into the sprite ROM
//  address and a hit flag. Supports horizontal mirroring and animation frame sequencing.
//  Sits between the VGA controller (draw_x/draw_y/vde) and the sprite ROM (rom_address).
//  Emits a hit flag that is pipeline-aligned with the registered palette pixel, for layer muxing.
// PARAMETERS
//  SPR_W       80   sprite width in pixels
//  SPR_H       120  sprite height in pixels
//  FRAMES      3    animation frames stored back-to-back in ROM (frame f base = f*SPR_W*SPR_H)
//  FRAME_HOLD  8    video frames each animation frame is displayed (>=1)
//  ADDR_W      15   ROM address width; FRAMES*SPR_W*SPR_H must be <= 2**ADDR_W
// PORTS
//  vga_clk      in   1       pixel clock; all logic on posedge
//  reset_n      in   1       synchronous, active-low reset
//  draw_x       in   10      current pixel column
//  draw_y       in   10      current pixel row
//  vde          in   1       1 = active video (same sense as ROM/palette "blank" input)
//  frame_start  in   1       1-cycle pulse once per video frame, during vertical blanking
//  pos_x        in   10      sprite top-left column (sampled at frame_start)
//  pos_y        in   10      sprite top-left row (sampled at frame_start)
//  facing_left  in   1       1 = mirror horizontally (sampled at frame_start)
//  anim_en      in   1       1 = cycle animation frames (sampled at frame_start)
//  rom_address  out  ADDR_W  sprite ROM address, registered
//  sprite_on    out  1       hit flag aligned with rom_address (stage 1)
//  sprite_on_px out  1       hit flag aligned with the palette pixel register (stage 2)
//  frame_idx    out  2       current animation frame
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): rom_address=0, sprite_on=0, sprite_on_px=0, frame_idx=0.
//   Reset also clears hold_cnt and shadow regs (sx=0, sy=0, sface=0, sanim=0).
//   Reset mid-line drops the hit flags on the next edge. No X on any output.
//  Shadow regs: on frame_start, load sx<=pos_x, sy<=pos_y, sface<=facing_left, sanim<=anim_en.
//   Position and facing never change mid-frame, so no tearing.
//  Animation FSM, states HOLD/ADVANCE, evaluated only on frame_start cycles:
//   - If anim_en=0 at frame_start: frame_idx<=0 and hold_cnt<=0. This overrides advance.
//   - Otherwise hold_cnt increments each frame_start.
//   - When hold_cnt==FRAME_HOLD-1 (ADVANCE): hold_cnt<=0, frame_idx<=frame_idx+1.
//   - frame_idx wraps FRAMES-1 -> 0.
//   - frame_start held high for multiple cycles counts once per cycle (illegal input, not guarded).
//  Hit test (stage 0, combinational on registered shadows):
//   rel_x = {1'b0,draw_x} - {1'b0,sx} (11 bit); rel_y likewise.
//   hit = vde & ~rel_x[10] & (rel_x < SPR_W) & ~rel_y[10] & (rel_y < SPR_H).
//   Sprites extending past x=639 or y=479 clip naturally; no wrap to the left or top edge.
//  Address: col = sface ? (SPR_W-1-rel_x) : rel_x.
//   addr = frame_idx*SPR_W*SPR_H + rel_y*SPR_W + col, computed at full width, truncated to ADDR_W.
//  Latency: inputs at edge N appear as rom_address/sprite_on at edge N+1.
//   sprite_on_px = sprite_on delayed one more cycle (edge N+2), matching the negedge ROM read
//   and the posedge palette register downstream.
//  Non-hit pixels: rom_address<=0 and sprite_on<=0. The downstream palette index 0 is transparent.
//  frame_start coinciding with an active pixel (illegal) still updates shadows. The hit test for
//   that same pixel uses the old shadow values.
// TESTING
//  1. Reset: hold reset_n=0 for 3 cycles with vde=1 over the sprite -> all outputs 0.
//     Release -> first hit appears no earlier than 1 cycle later.
//  2. pos=(100,50), facing_left=0, frame 0, draw=(100,50) -> next cycle rom_address=0, sprite_on=1.
//     draw=(179,169) -> rom_address=9599. sprite_on_px follows sprite_on by exactly 1 cycle.
//  3. Mirror: facing_left=1, pos=(100,50), draw=(100,50) -> rom_address=79.
//     draw=(179,51) -> rom_address=80.
//  4. Clip/bounds: draw=(99,50), (180,50) and (100,170) -> sprite_on=0, rom_address=0.
//     pos_x=600, draw_x=639 -> hit. vde=0 inside the box -> no hit.
//  5. Animation: anim_en=1, FRAME_HOLD=8. Issue 8 frame_start pulses -> frame_idx=1.
//     After 24 pulses -> 0 (wrap). With frame_idx=2, draw at top-left -> rom_address=19200.
//  6. Override/latching: change pos_x mid-frame -> hit box unchanged until the next frame_start.
//     Drop anim_en with frame_idx=2 -> frame_idx=0 after that frame_start.

Source files
------------

// File: rtl/kyo_sprite_fetch.sv
// Sprite fetch: turns VGA draw coordinates into a sprite ROM address and a hit flag.
// The sprite can be mirrored horizontally and can cycle through animation frames.
// Stage 0 is the hit test and address computation. Stage 1 registers rom_address and sprite_on.
// Stage 2 delays the hit flag so that it lines up with the palette pixel register.
module kyo_sprite_fetch #(
   parameter int SPR_W      = 80,
   parameter int SPR_H      = 120,
   parameter int FRAMES     = 3,
   parameter int FRAME_HOLD = 8,
   parameter int ADDR_W     = 15
)(
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic [9:0]        draw_x,
   input  logic [9:0]        draw_y,
   input  logic              vde,
   input  logic              frame_start,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic              facing_left,
   input  logic              anim_en,
   output logic [ADDR_W-1:0] rom_address,
   output logic              sprite_on,
   output logic              sprite_on_px,
   output logic [1:0]        frame_idx
);

   localparam int HC_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
   localparam int FRAME_SZ = SPR_W * SPR_H;

   typedef enum logic {HOLD, ADVANCE} anim_state_t;
   // With a hold of one, every enabled frame_start advances.
   localparam anim_state_t ST_INIT = (FRAME_HOLD == 1) ? ADVANCE : HOLD;

   // Position and facing are shadowed once per frame, so the sprite never tears mid-frame.
   // anim_en is consumed directly on the frame_start cycle, so it needs no shadow.
   logic [9:0]      sx, sy;
   logic            sface;
   logic [HC_W-1:0] hold_cnt;
   anim_state_t     state;

   logic [10:0]       rel_x, rel_y, col;
   logic              hit;
   logic [ADDR_W-1:0] addr;
   logic [2:1]        vld_pipe;

   // Shadow load and animation sequencing. Both act only on frame_start cycles.
   // ADVANCE means that the next enabled frame_start moves on to the next frame.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         sx        <= '0;
         sy        <= '0;
         sface     <= 1'b0;
         hold_cnt  <= '0;
         frame_idx <= '0;
         state     <= ST_INIT;
      end else if (frame_start) begin
         sx    <= pos_x;
         sy    <= pos_y;
         sface <= facing_left;
         if (!anim_en) begin
            hold_cnt  <= '0;
            frame_idx <= '0;
            state     <= ST_INIT;
         end else if (state == ADVANCE) begin
            hold_cnt  <= '0;
            frame_idx <= (frame_idx == 2'(FRAMES-1)) ? 2'd0 : frame_idx + 2'd1;
            state     <= ST_INIT;
         end else begin
            hold_cnt <= hold_cnt + 1'b1;
            state    <= (hold_cnt == HC_W'(FRAME_HOLD-2)) ? ADVANCE : HOLD;
         end
      end
   end

   // Hit test on the registered shadows. A negative offset sets bit 10, which blocks any wrap.
   // The address arithmetic is done modulo 2**ADDR_W, which is the same as a full-width truncation.
   always_comb begin
      rel_x = {1'b0, draw_x} - {1'b0, sx};
      rel_y = {1'b0, draw_y} - {1'b0, sy};
      hit   = vde & ~rel_x[10] & (rel_x < 11'(SPR_W)) & ~rel_y[10] & (rel_y < 11'(SPR_H));
      col   = sface ? (11'(SPR_W-1) - rel_x) : rel_x;
      addr  = ADDR_W'(frame_idx) * ADDR_W'(FRAME_SZ)
            + ADDR_W'(rel_y) * ADDR_W'(SPR_W)
            + ADDR_W'(col);
   end

   // Stage 1 holds the address and the hit flag. Stage 2 holds the hit flag for the palette pixel.
   // Non-hit pixels fetch address 0, which maps to the transparent palette index.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         rom_address <= '0;
         vld_pipe    <= '0;
      end else begin
         rom_address <= hit ? addr : '0;
         vld_pipe    <= {vld_pipe[1], hit};
      end
   end

   assign sprite_on    = vld_pipe[1];
   assign sprite_on_px = vld_pipe[2];

endmodule

// File: tb/tb_kyo_sprite_fetch.sv
// Bench for kyo_sprite_fetch.
// Each step drives one pixel and pushes the expected stage-1 result onto a queue.
// The result is popped and compared once the DUT has registered it.
// Static geometry cases come from a table. Animation, latching and reset are hand-written sequences.
module tb_kyo_sprite_fetch;

   logic        vga_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [9:0]  draw_x = '0, draw_y = '0, pos_x = '0, pos_y = '0;
   logic        vde = 1'b0, frame_start = 1'b0, facing_left = 1'b0, anim_en = 1'b0;
   logic [14:0] rom_address;
   logic        sprite_on, sprite_on_px;
   logic [1:0]  frame_idx;

   kyo_sprite_fetch dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y), .vde(vde),
      .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .facing_left(facing_left),
      .anim_en(anim_en), .rom_address(rom_address), .sprite_on(sprite_on),
      .sprite_on_px(sprite_on_px), .frame_idx(frame_idx)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct {int addr; logic on;} exp_t;
   typedef struct {int px; int py; logic face; int x; int y; logic v; int addr; logic on;} vec_t;

   exp_t q[$];
   int   n_cmp = 0, n_bad = 0;

   // bench model of the shadows and the animation counter
   int   m_px = 0, m_py = 0, m_hc = 0, m_fidx = 0;
   logic m_face = 1'b0;
   logic last_on = 1'b0;
   // values presented on pos_x/pos_y/facing_left/anim_en
   int   d_px = 0, d_py = 0;
   logic d_face = 1'b0, d_anim = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic m_hit(input int x, input int y, input logic v);
      return v && (x >= m_px) && (x < m_px + 80) && (y >= m_py) && (y < m_py + 120);
   endfunction

   function automatic int m_addr(input int x, input int y, input logic v);
      int c;
      if (!m_hit(x, y, v)) return 0;
      c = m_face ? 79 - (x - m_px) : (x - m_px);
      return (m_fidx * 9600 + (y - m_py) * 80 + c) % 32768;
   endfunction

   // Drive one pixel cycle and check the registered result after the edge.
   task automatic step(input logic rst, input logic fs, input int x, input int y, input logic v,
                       input int e_addr, input logic e_on);
      exp_t e;
      @(negedge vga_clk);
      reset_n = rst; frame_start = fs; draw_x = 10'(x); draw_y = 10'(y); vde = v;
      pos_x = 10'(d_px); pos_y = 10'(d_py); facing_left = d_face; anim_en = d_anim;
      q.push_back('{rst ? e_addr : 0, rst ? e_on : 1'b0});
      if (!rst) begin
         m_px = 0; m_py = 0; m_face = 0; m_hc = 0; m_fidx = 0;
      end else if (fs) begin
         m_px = d_px; m_py = d_py; m_face = d_face;
         if (!d_anim) begin m_hc = 0; m_fidx = 0; end
         else if (m_hc == 7) begin m_hc = 0; m_fidx = (m_fidx + 1) % 3; end
         else m_hc++;
      end
      @(posedge vga_clk);
      #1;
      e = q.pop_front();
      chk("rom_address", int'(rom_address), e.addr);
      chk("sprite_on", int'(sprite_on), int'(e.on));
      chk("sprite_on_px", int'(sprite_on_px), rst ? int'(last_on) : 0);
      chk("frame_idx", int'(frame_idx), m_fidx);
      last_on = rst ? e.on : 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic pix(input int x, input int y, input logic v);
      step(1'b1, 1'b0, x, y, v, m_addr(x, y, v), m_hit(x, y, v));
   endtask

   task automatic pulse();
      step(1'b1, 1'b1, 0, 0, 1'b0, 0, 1'b0);
   endtask

   vec_t tab[18];

   initial begin
      tab[0]  = '{100, 50, 1'b0, 100,  50, 1'b1,    0, 1'b1};
      tab[1]  = '{100, 50, 1'b0, 179, 169, 1'b1, 9599, 1'b1};
      tab[2]  = '{100, 50, 1'b0, 101,  50, 1'b1,    1, 1'b1};
      tab[3]  = '{100, 50, 1'b0, 100,  51, 1'b1,   80, 1'b1};
      tab[4]  = '{100, 50, 1'b0,  99,  50, 1'b1,    0, 1'b0};
      tab[5]  = '{100, 50, 1'b0, 180,  50, 1'b1,    0, 1'b0};
      tab[6]  = '{100, 50, 1'b0, 100, 170, 1'b1,    0, 1'b0};
      tab[7]  = '{100, 50, 1'b0, 150, 100, 1'b0,    0, 1'b0};
      tab[8]  = '{100, 50, 1'b0, 100,  49, 1'b1,    0, 1'b0};
      tab[9]  = '{100, 50, 1'b1, 100,  50, 1'b1,   79, 1'b1};
      tab[10] = '{100, 50, 1'b1, 179,  51, 1'b1,   80, 1'b1};
      tab[11] = '{100, 50, 1'b1, 179,  50, 1'b1,    0, 1'b1};
      tab[12] = '{100, 50, 1'b1, 120,  60, 1'b1,  859, 1'b1};
      tab[13] = '{600, 50, 1'b0, 639,  50, 1'b1,   39, 1'b1};
      tab[14] = '{600, 50, 1'b0,   5,  50, 1'b1,    0, 1'b0};
      tab[15] = '{600,400, 1'b0, 600, 479, 1'b1, 6320, 1'b1};
      tab[16] = '{1000,50, 1'b0,  10,  50, 1'b1,    0, 1'b0};
      tab[17] = '{1000,50, 1'b0,1023,  50, 1'b1,   23, 1'b1};

      // reset held for three cycles with an active pixel over the reset-state sprite
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b1, 0, 1'b0);
      pix(0, 0, 1'b1);
      pix(1, 0, 1'b1);

      // table of static geometry cases; reload shadows whenever the row's placement changes
      for (int i = 0; i < 18; i++) begin
         if (tab[i].px != m_px || tab[i].py != m_py || tab[i].face != m_face) begin
            d_px = tab[i].px; d_py = tab[i].py; d_face = tab[i].face; d_anim = 1'b0;
            pulse();
         end
         step(1'b1, 1'b0, tab[i].x, tab[i].y, tab[i].v, tab[i].addr, tab[i].on);
      end

      // animation sequencing with a hold of eight frame_start pulses
      d_px = 100; d_py = 50; d_face = 1'b0; d_anim = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         pulse();
         if (i == 7)  chk("frame_after_7", int'(frame_idx), 0);
         if (i == 8)  chk("frame_after_8", int'(frame_idx), 1);
         if (i == 16) begin
            chk("frame_after_16", int'(frame_idx), 2);
            step(1'b1, 1'b0, 100, 50, 1'b1, 19200, 1'b1);
            step(1'b1, 1'b0, 179, 169, 1'b1, 28799, 1'b1);
         end
         if (i == 24) chk("frame_wrap_24", int'(frame_idx), 0);
      end
      for (int i = 0; i < 16; i++) pulse();

      // a frame_start on an active pixel still tests that pixel against the old shadows
      d_px = 300;
      step(1'b1, 1'b1, 100, 50, 1'b1, 19200, 1'b1);
      pix(100, 50, 1'b1);
      pix(300, 50, 1'b1);

      // a mid-frame change of pos_x leaves the hit box where it is
      d_px = 100;
      step(1'b1, 1'b0, 300, 50, 1'b1, 19200, 1'b1);
      pix(100, 50, 1'b1);

      // dropping anim_en resets the frame on that frame_start
      d_anim = 1'b0;
      pulse();
      chk("anim_off_frame", int'(frame_idx), 0);
      step(1'b1, 1'b0, 100, 50, 1'b1, 0, 1'b1);

      // a mid-line reset with a nonzero frame clears everything on the next edge
      d_anim = 1'b1;
      for (int i = 0; i < 8; i++) pulse();
      step(1'b1, 1'b0, 100, 50, 1'b1, 9600, 1'b1);
      step(1'b0, 1'b0, 101, 50, 1'b1, 0, 1'b0);
      pix(0, 0, 1'b1);
      pix(100, 50, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
